core_seq_ctrl: RTL
==================

// Module: core_seq_ctrl
// PURPOSE
//  Hardware sequencer that drives the core's 34-bit instruction word through a full 3x3 conv tile,
//  replacing bench-driven stepping. Per kij it loads weights (xmem->L0->PE), streams activations
//  (xmem->L0), executes and drains the OFIFO into pmem. It then runs the per-output pmem
//  accumulation and flags each valid sfp_out word. Sits between host/start logic and core.inst.
// PARAMETERS
//  COL 8 PE columns / weight words per kij | ROW 8 PE rows
//  LEN_NIJ 36 input pixels (6x6) | LEN_ONIJ 16 output pixels (4x4) | LEN_KIJ 9 kernel taps (3x3)
//  W_BASE 11'h400 xmem weight base | PSUM_STRIDE 37 pmem words per kij (LEN_NIJ+1)
//  CORE_RST_CYC 2 core_rst pulse length | GAP_CYC 10 post-load intermission | OFIFO_TO 64 valid timeout
// PORTS
//  clk          in  1   clock, all state on rising edge
//  reset        in  1   asynchronous, active-low (0 = reset)
//  start        in  1   1-cycle pulse: begin tile; ignored while busy
//  ofifo_valid  in  1   core OFIFO has data
//  inst         out 34  core instruction {acc,CEN_p,WEN_p,A_p[10:0],CEN_x,WEN_x,A_x[10:0],ofifo_rd,ififo_wr,ififo_rd,l0_rd,l0_wr,execute,load}
//  core_rst     out 1   active-high core reset pulse
//  busy         out 1   high from accepted start until done
//  done         out 1   1-cycle pulse at tile end
//  err_to       out 1   sticky: OFIFO timeout; cleared by next accepted start
//  kij_idx      out 4   current kernel tap 0..8
//  sfp_valid    out 1   1-cycle pulse: core sfp_out holds output out_idx
//  out_idx      out 4   output pixel 0..15 of current sfp_valid
// BEHAVIOUR
//  - All outputs registered. Reset: inst=34'h1_800C_0000 (CEN/WEN both mems =1, rest 0); other outputs 0, FSM=IDLE.
//  - Reset mid-operation aborts immediately to IDLE; no partial done/sfp_valid emitted.
//  - FSM: IDLE -start-> KRST(CORE_RST_CYC, core_rst=1) -> W_L0 -> W_LD -> GAP -> A_L0 -> EXEC -> OF_WAIT
//    -> OF_RD -> (kij<8 ? kij++,KRST : ACC) ; ACC per output: ORST -> ACC_RD -> ACC_OUT ; after out 15 -> DONE -> IDLE.
//  - W_L0: COL+1 cycles; CEN_x=0,WEN_x=1, A_x=W_BASE+t; l0_wr=1 one cycle after each read address (SRAM latency 1).
//  - W_LD: COL cycles l0_rd=1,load=1. GAP: GAP_CYC idle cycles, all strobes 0.
//  - A_L0: LEN_NIJ+1 cycles, A_x=t (0..35), l0_wr lags address by 1 cycle.
//  - EXEC: LEN_NIJ+ROW+COL cycles; execute=l0_rd=1 for first LEN_NIJ, then 0 (array drain).
//  - OF_WAIT: wait ofifo_valid; >OFIFO_TO cycles -> err_to=1, busy=0, IDLE (no done).
//  - OF_RD: LEN_NIJ+1 cycles ofifo_rd=1, CEN_p=0,WEN_p=0, A_p=kij*PSUM_STRIDE+t.
//  - ACC for output o (oi=o/4, oj=o%4), tap j (ki=j/3, kj=j%3): CEN_p=0,WEN_p=1,
//    A_p=j*PSUM_STRIDE+(oi+ki)*6+(oj+kj); 9 reads j=0..8, acc=1 on cycles 2..10 (1-cycle lag to read data).
//  - ORST: core_rst 1 cycle before each output; ACC_OUT: sfp_valid=1, out_idx=o, 1 cycle after last acc.
//  - Address arithmetic 11-bit unsigned; max A_p=8*37+36=332, no wrap. kij_idx/out_idx saturate at 8/15.
//  - start during busy: ignored. start with done same cycle: accepted next IDLE cycle only.
// CONFIGURATION
//  - SEQ_PERF_CNT_EN defined: adds out 16-bit cyc_cnt, cleared on accepted start, increments while busy,
//    saturates at 16'hFFFF, held after done. Undefined: port absent, no counter logic.
// TESTING
//  - Reset asserted mid-EXEC (kij=3) -> inst=34'h1_800C_0000, busy=0 asynchronously; new start runs kij 0..8.
//  - start pulse -> core_rst high 2 cycles; W_L0 A_x 0x400..0x407; l0_wr first high 1 cycle after A_x=0x400.
//  - EXEC phase -> execute high exactly 36 cycles, low 16 more; OF_RD writes A_p 0..36 for kij0, 296..332 for kij8.
//  - Output 5 (oi=1,oj=1), tap 4 -> A_p=4*37+2*6+2=162; 16 sfp_valid pulses, out_idx 0..15, then done 1 cycle.
//  - ofifo_valid tied 0 -> err_to=1 after 64 wait cycles, busy=0, no done; next start clears err_to.
//  - start held high whole run -> one tile only, no restart until IDLE; SEQ_PERF_CNT_EN: cyc_cnt stable after done.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// ---------------------------------------------------------------------------
// core_seq_ctrl
// Sequencer that steps the core's 34-bit instruction word through one full
// 3x3 conv tile: for each kernel tap it loads weights (xmem->L0->PE), streams
// activations (xmem->L0), executes, and drains the OFIFO into pmem. It then
// accumulates the nine partial sums of every output pixel and flags each
// valid sfp_out word.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        asynchronous, active-low
//   start        1-cycle pulse, begins a tile; ignored unless idle
//   ofifo_valid  core OFIFO has data
//   inst         core instruction {acc,CEN_p,WEN_p,A_p,CEN_x,WEN_x,A_x,
//                ofifo_rd,ififo_wr,ififo_rd,l0_rd,l0_wr,execute,load}
//   core_rst     active-high core reset pulse
//   busy         high from accepted start until done (or timeout)
//   done         1-cycle pulse at tile end
//   err_to       sticky OFIFO timeout, cleared by the next accepted start
//   kij_idx      current kernel tap
//   sfp_valid    1-cycle pulse, core sfp_out holds output out_idx
//   out_idx      output pixel of the current sfp_valid
//   cyc_cnt      (SEQ_PERF_CNT_EN only) saturating busy-cycle counter
//
// Build option: define SEQ_PERF_CNT_EN to add the cyc_cnt port and counter.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// KRST      | core_rst pulse before each kernel tap
// W_L0      | weight words xmem -> L0 (read address leads l0_wr by 1)
// W_LD      | weights L0 -> PE (l0_rd + load)
// GAP       | intermission after the weight load, all strobes low
// A_L0      | activations xmem -> L0
// EXEC      | execute for LEN_NIJ cycles, then let the array drain
// OF_WAIT   | wait for ofifo_valid, bounded by OFIFO_TO
// OF_RD     | OFIFO -> pmem at kij*PSUM_STRIDE + t
// ORST      | core_rst pulse before each output pixel
// ACC_RD    | nine pmem reads, acc lags each read by one cycle
// ACC_OUT   | sfp_valid pulse for the finished output pixel
// DONE      | done pulse
// ---------------------------------------------------------------------------
module core_seq_ctrl #(
   parameter int          COL          = 8,
   parameter int          ROW          = 8,
   parameter int          IN_DIM       = 6,
   parameter int          OUT_DIM      = 4,
   parameter int          LEN_NIJ      = 36,
   parameter int          LEN_ONIJ     = 16,
   parameter int          LEN_KIJ      = 9,
   parameter logic [10:0] W_BASE       = 11'h400,
   parameter int          PSUM_STRIDE  = 37,
   parameter int          CORE_RST_CYC = 2,
   parameter int          GAP_CYC      = 10,
   parameter int          OFIFO_TO     = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ofifo_valid,
   output logic [33:0] inst,
   output logic        core_rst,
   output logic        busy,
   output logic        done,
   output logic        err_to,
   output logic [3:0]  kij_idx,
   output logic        sfp_valid,
   output logic [3:0]  out_idx
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [15:0] cyc_cnt
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_KRST, S_W_L0, S_W_LD, S_GAP, S_A_L0, S_EXEC,
      S_OF_WAIT, S_OF_RD, S_ORST, S_ACC_RD, S_ACC_OUT, S_DONE
   } state_t;

   localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

   localparam logic [6:0]  KRST_LAST = 7'(CORE_RST_CYC - 1);
   localparam logic [6:0]  WL0_LAST  = 7'(COL);
   localparam logic [6:0]  WLD_LAST  = 7'(COL - 1);
   localparam logic [6:0]  GAP_LAST  = 7'(GAP_CYC - 1);
   localparam logic [6:0]  AL0_LAST  = 7'(LEN_NIJ);
   localparam logic [6:0]  EXEC_LAST = 7'(LEN_NIJ + ROW + COL - 1);
   localparam logic [6:0]  WAIT_LAST = 7'(OFIFO_TO - 1);
   localparam logic [6:0]  OFRD_LAST = 7'(LEN_NIJ);
   localparam logic [6:0]  ACC_LAST  = 7'(LEN_KIJ);
   localparam logic [6:0]  COL_C     = 7'(COL);
   localparam logic [6:0]  NIJ_C     = 7'(LEN_NIJ);
   localparam logic [6:0]  KIJ_C     = 7'(LEN_KIJ);
   localparam logic [3:0]  KIJ_LAST  = 4'(LEN_KIJ - 1);
   localparam logic [3:0]  OUT_LAST  = 4'(LEN_ONIJ - 1);
   localparam logic [10:0] PS        = 11'(PSUM_STRIDE);
   localparam logic [10:0] IN_W      = 11'(IN_DIM);
   localparam logic [10:0] OUT_W     = 11'(OUT_DIM);
   localparam logic [10:0] K_W       = 11'd3;

   state_t      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [3:0]  kij_q, kij_d;
   logic [3:0]  out_q, out_d;
   logic        err_to_q, err_to_d;
   logic [33:0] inst_q, inst_d;
   logic        core_rst_q, core_rst_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        sfp_valid_q, sfp_valid_d;

   logic        acc, cen_p, wen_p, cen_x, wen_x;
   logic        of_rd, l0_rd, l0_wr, exe, ld;
   logic [10:0] a_p, a_x;
   logic [10:0] tap_j, tap_ki, tap_kj, o_n, o_i, o_j;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 7'd1;
      kij_d    = kij_q;
      out_d    = out_q;
      err_to_d = err_to_q;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d  = S_KRST;
               kij_d    = '0;
               out_d    = '0;
               err_to_d = 1'b0;
            end
         end
         S_KRST:    if (cnt_q == KRST_LAST) begin state_d = S_W_L0;    cnt_d = '0; end
         S_W_L0:    if (cnt_q == WL0_LAST)  begin state_d = S_W_LD;    cnt_d = '0; end
         S_W_LD:    if (cnt_q == WLD_LAST)  begin state_d = S_GAP;     cnt_d = '0; end
         S_GAP:     if (cnt_q == GAP_LAST)  begin state_d = S_A_L0;    cnt_d = '0; end
         S_A_L0:    if (cnt_q == AL0_LAST)  begin state_d = S_EXEC;    cnt_d = '0; end
         S_EXEC:    if (cnt_q == EXEC_LAST) begin state_d = S_OF_WAIT; cnt_d = '0; end
         S_OF_WAIT: begin
            if (ofifo_valid) begin
               state_d = S_OF_RD;
               cnt_d   = '0;
            end else if (cnt_q == WAIT_LAST) begin
               // Timeout abandons the tile without a done pulse.
               state_d  = S_IDLE;
               cnt_d    = '0;
               err_to_d = 1'b1;
            end
         end
         S_OF_RD: begin
            if (cnt_q == OFRD_LAST) begin
               cnt_d = '0;
               if (kij_q < KIJ_LAST) begin
                  state_d = S_KRST;
                  kij_d   = kij_q + 4'd1;
               end else begin
                  state_d = S_ORST;
                  out_d   = '0;
               end
            end
         end
         S_ORST:    begin state_d = S_ACC_RD; cnt_d = '0; end
         S_ACC_RD:  if (cnt_q == ACC_LAST) begin state_d = S_ACC_OUT; cnt_d = '0; end
         S_ACC_OUT: begin
            cnt_d = '0;
            if (out_q < OUT_LAST) begin
               state_d = S_ORST;
               out_d   = out_q + 4'd1;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE:    begin state_d = S_IDLE; cnt_d = '0; end
         default:   begin state_d = S_IDLE; cnt_d = '0; end
      endcase

      // Outputs are decoded from the next-state values so the registered
      // outputs line up with the state register.
      acc         = 1'b0;
      cen_p       = 1'b1;
      wen_p       = 1'b1;
      a_p         = '0;
      cen_x       = 1'b1;
      wen_x       = 1'b1;
      a_x         = '0;
      of_rd       = 1'b0;
      l0_rd       = 1'b0;
      l0_wr       = 1'b0;
      exe         = 1'b0;
      ld          = 1'b0;
      core_rst_d  = 1'b0;
      sfp_valid_d = 1'b0;
      done_d      = 1'b0;
      tap_j       = {7'd0, cnt_d[3:0]};
      tap_ki      = tap_j / K_W;
      tap_kj      = tap_j % K_W;
      o_n         = {7'd0, out_d};
      o_i         = o_n / OUT_W;
      o_j         = o_n % OUT_W;

      unique case (state_d)
         S_KRST, S_ORST: core_rst_d = 1'b1;
         S_W_L0: begin
            if (cnt_d < COL_C) begin
               cen_x = 1'b0;
               a_x   = W_BASE + {4'd0, cnt_d};
            end
            l0_wr = (cnt_d != 7'd0);
         end
         S_W_LD: begin
            l0_rd = 1'b1;
            ld    = 1'b1;
         end
         S_A_L0: begin
            if (cnt_d < NIJ_C) begin
               cen_x = 1'b0;
               a_x   = {4'd0, cnt_d};
            end
            l0_wr = (cnt_d != 7'd0);
         end
         S_EXEC: begin
            exe   = (cnt_d < NIJ_C);
            l0_rd = (cnt_d < NIJ_C);
         end
         S_OF_RD: begin
            of_rd = 1'b1;
            cen_p = 1'b0;
            wen_p = 1'b0;
            a_p   = {7'd0, kij_d} * PS + {4'd0, cnt_d};
         end
         S_ACC_RD: begin
            if (cnt_d < KIJ_C) begin
               cen_p = 1'b0;
               a_p   = tap_j * PS + (o_i + tap_ki) * IN_W + o_j + tap_kj;
            end
            acc = (cnt_d != 7'd0);
         end
         S_ACC_OUT: sfp_valid_d = 1'b1;
         S_DONE:    done_d = 1'b1;
         default:   ;
      endcase

      busy_d = (state_d != S_IDLE);
      inst_d = {acc, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
                of_rd, 1'b0, 1'b0, l0_rd, l0_wr, exe, ld};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         kij_q       <= '0;
         out_q       <= '0;
         err_to_q    <= 1'b0;
         inst_q      <= INST_IDLE;
         core_rst_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sfp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         kij_q       <= kij_d;
         out_q       <= out_d;
         err_to_q    <= err_to_d;
         inst_q      <= inst_d;
         core_rst_q  <= core_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sfp_valid_q <= sfp_valid_d;
      end
   end

   assign inst      = inst_q;
   assign core_rst  = core_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err_to    = err_to_q;
   assign kij_idx   = kij_q;
   assign sfp_valid = sfp_valid_q;
   assign out_idx   = out_q;

`ifdef SEQ_PERF_CNT_EN
   logic [15:0] cyc_cnt_q, cyc_cnt_d;

   always_comb begin
      cyc_cnt_d = cyc_cnt_q;
      if (state_q == S_IDLE && start) begin
         cyc_cnt_d = '0;
      end else if (busy_q && cyc_cnt_q != 16'hFFFF) begin
         cyc_cnt_d = cyc_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cyc_cnt_q <= '0;
      else        cyc_cnt_q <= cyc_cnt_d;
   end

   assign cyc_cnt = cyc_cnt_q;
`endif

endmodule
